// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with runtime upper bound, wrap or saturate behaviour,
// parallel load and registered one-cycle Wrap/Sat event pulses.
module updown_counter_param #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             Enable,
  input  logic             UpDown,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] Limit,
  output logic [WIDTH-1:0] Count,
  output logic             Wrap,
  output logic             Sat,
  output logic             TermCnt
);

  localparam logic [WIDTH-1:0] resetCount = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] nextCount;
  logic             nextWrap;
  logic             nextSat;

  // A loaded value above Limit is kept as-is; an up step from there folds back into range.
  always_comb begin
    nextCount = Count;
    nextWrap  = 1'b0;
    nextSat   = 1'b0;
    if (Load) begin
      nextCount = LoadVal;
    end else if (Enable) begin
      if (UpDown) begin
        if (Count < Limit) begin
          nextCount = Count + 1'b1;
        end else if (Mode) begin
          nextCount = Limit;
          nextSat   = 1'b1;
        end else begin
          nextCount = '0;
          nextWrap  = 1'b1;
        end
      end else begin
        if (Count != '0) begin
          nextCount = Count - 1'b1;
        end else if (Mode) begin
          nextSat   = 1'b1;
        end else begin
          nextCount = Limit;
          nextWrap  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Count <= resetCount;
      Wrap  <= 1'b0;
      Sat   <= 1'b0;
    end else begin
      Count <= nextCount;
      Wrap  <= nextWrap;
      Sat   <= nextSat;
    end
  end

  assign TermCnt = UpDown ? (Count == Limit) : (Count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural range model.
module tb_updown_counter_param;

  localparam int W      = 4;
  localparam int RSTVAL = 3;

  logic         Clk = 1'b0;
  logic         reset_n;
  logic         Enable, UpDown, Mode, Load;
  logic [W-1:0] LoadVal, Limit;
  logic [W-1:0] Count;
  logic         Wrap, Sat, TermCnt;

  int checks   = 0;
  int failures = 0;

  int mCount;
  bit mWrap, mSat;

  updown_counter_param #(.WIDTH(W), .RESET_VAL(RSTVAL)) dut (
    .Clk(Clk), .reset_n(reset_n), .Enable(Enable), .UpDown(UpDown), .Mode(Mode),
    .Load(Load), .LoadVal(LoadVal), .Limit(Limit), .Count(Count), .Wrap(Wrap),
    .Sat(Sat), .TermCnt(TermCnt)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the count lives in 0..Limit (or above it only after a load); stepping past
  // an end either folds to the other end (wrap) or is refused (saturate).
  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      mCount = RSTVAL;
      mWrap  = 0;
      mSat   = 0;
    end else begin
      mWrap = 0;
      mSat  = 0;
      if (Load) mCount = int'(LoadVal);
      else if (Enable && UpDown) begin
        if (mCount < int'(Limit)) mCount = mCount + 1;
        else if (Mode) begin mCount = int'(Limit); mSat = 1; end
        else begin mCount = 0; mWrap = 1; end
      end else if (Enable) begin
        if (mCount > 0) mCount = mCount - 1;
        else if (Mode) mSat = 1;
        else begin mCount = int'(Limit); mWrap = 1; end
      end
    end
  end

  always @(negedge Clk) begin
    checkOutput("cmpCount", int'(Count), mCount);
    checkOutput("cmpWrap", int'(Wrap), int'(mWrap));
    checkOutput("cmpSat", int'(Sat), int'(mSat));
    checkOutput("cmpTermCnt", int'(TermCnt),
                UpDown ? int'(mCount == int'(Limit)) : int'(mCount == 0));
  end

  task automatic applyStimulus(input logic en, input logic ud, input logic md,
                               input logic ld, input logic [W-1:0] lv, input logic [W-1:0] lim);
    Enable  = en;
    UpDown  = ud;
    Mode    = md;
    Load    = ld;
    LoadVal = lv;
    Limit   = lim;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0;
    Enable = 0; UpDown = 1; Mode = 0; Load = 0; LoadVal = '0; Limit = 4'd9;
    #12;
    checkOutput("resetCount", int'(Count), RSTVAL);
    checkOutput("resetWrap", int'(Wrap), 0);
    checkOutput("resetSat", int'(Sat), 0);
    reset_n = 1'b1;

    // Wrapping up-count through Limit=9
    applyStimulus(0, 1, 0, 1, 4'd0, 4'd9);
    checkOutput("loadZero", int'(Count), 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 0, 0, 4'd0, 4'd9);
      checkOutput("upWrapCount", int'(Count), (i < 9) ? i + 1 : i - 9);
      checkOutput("upWrapPulse", int'(Wrap), (i == 9) ? 1 : 0);
      if (i == 8) checkOutput("termAtLimit", int'(TermCnt), 1);
    end

    // Saturating down-count from 2
    applyStimulus(0, 0, 1, 1, 4'd2, 4'd9);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 0, 4'd0, 4'd9);
      checkOutput("downSatCount", int'(Count), (i == 0) ? 1 : 0);
      checkOutput("downSatPulse", int'(Sat), (i >= 2) ? 1 : 0);
      checkOutput("downSatNoWrap", int'(Wrap), 0);
    end

    // Load above Limit, then recover in each direction and mode
    applyStimulus(1, 1, 0, 1, 4'd13, 4'd9);
    checkOutput("loadOverLimit", int'(Count), 13);
    checkOutput("loadNoWrap", int'(Wrap), 0);
    applyStimulus(1, 1, 0, 0, 4'd0, 4'd9);
    checkOutput("overLimitUpWrap", int'(Count), 0);
    checkOutput("overLimitWrapPulse", int'(Wrap), 1);
    applyStimulus(0, 0, 0, 1, 4'd13, 4'd9);
    applyStimulus(1, 0, 0, 0, 4'd0, 4'd9);
    checkOutput("overLimitDown", int'(Count), 12);
    applyStimulus(0, 1, 1, 1, 4'd13, 4'd9);
    applyStimulus(1, 1, 1, 0, 4'd0, 4'd9);
    checkOutput("overLimitUpSat", int'(Count), 9);
    checkOutput("overLimitSatPulse", int'(Sat), 1);

    // Direction change and hold
    applyStimulus(0, 1, 0, 1, 4'd4, 4'd9);
    applyStimulus(1, 1, 0, 0, 4'd0, 4'd9);
    checkOutput("upToFive", int'(Count), 5);
    applyStimulus(1, 0, 0, 0, 4'd0, 4'd9);
    checkOutput("flipDown1", int'(Count), 4);
    applyStimulus(1, 0, 0, 0, 4'd0, 4'd9);
    checkOutput("flipDown2", int'(Count), 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 4'd0, 4'd2);
      checkOutput("holdCount", int'(Count), 3);
    end

    // Asynchronous reset between edges while Count=7, Wrap=1
    applyStimulus(0, 0, 0, 1, 4'd0, 4'd7);
    applyStimulus(1, 0, 0, 0, 4'd0, 4'd7);
    checkOutput("downWrapToLimit", int'(Count), 7);
    checkOutput("downWrapPulse", int'(Wrap), 1);
    UpDown = 1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncResetCount", int'(Count), RSTVAL);
    checkOutput("asyncResetWrap", int'(Wrap), 0);
    @(posedge Clk); #1;
    checkOutput("heldInReset", int'(Count), RSTVAL);
    #2 reset_n = 1'b1;
    @(posedge Clk); #1;
    checkOutput("firstEdgeAfterReset", int'(Count), RSTVAL + 1);
    checkOutput("noPulseAfterReset", int'(Wrap) + int'(Sat), 0);

    // Limit=0 pins the count at zero
    applyStimulus(0, 1, 0, 1, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 4'd0, 4'd0);
      checkOutput("zeroLimitCount", int'(Count), 0);
      checkOutput("zeroLimitWrap", int'(Wrap), 1);
      checkOutput("zeroLimitTermUp", int'(TermCnt), 1);
    end
    applyStimulus(1, 0, 0, 0, 4'd0, 4'd0);
    checkOutput("zeroLimitTermDown", int'(TermCnt), 1);
    checkOutput("zeroLimitDownWrap", int'(Wrap), 1);
    applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);
    checkOutput("zeroLimitSat", int'(Sat), 1);
    checkOutput("zeroLimitSatCount", int'(Count), 0);

    // Mixed traffic checked by the model each cycle
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    @(negedge Clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
